// File: rtl/mem_port_arbiter.sv
// Shares the single data-RAM port between the pipeline MEM stage and a debug dump engine.
// The dump engine streams every RAM word, in address order, over a valid/ready channel.
//
// state | meaning
// IDLE  | pipeline owns the RAM port
// READ  | RAM word at counter is captured into the dump registers
// SEND  | captured word is offered to the debug unit until it is accepted
// DONE  | one-cycle completion pulse, then the port returns to the pipeline
module mem_port_arbiter #(
  parameter int NB_WIDTH = 32,
  parameter int NB_ADDR  = 9
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_pipe_read,
  input  logic                i_pipe_write,
  input  logic [NB_WIDTH-1:0] i_pipe_addr,
  input  logic [NB_WIDTH-1:0] i_pipe_wdata,
  input  logic [2:0]          i_pipe_bhw,
  output logic                o_mem_we,
  output logic [NB_WIDTH-1:0] o_mem_addr,
  output logic [NB_WIDTH-1:0] o_mem_wdata,
  output logic [2:0]          o_mem_bhw,
  input  logic [NB_WIDTH-1:0] i_mem_rdata,
  output logic [NB_WIDTH-1:0] o_pipe_rdata,
  output logic                o_pipe_stall,
  input  logic                i_dump_start,
  input  logic                i_dump_abort,
  output logic                o_dump_valid,
  output logic [NB_WIDTH-1:0] o_dump_data,
  output logic [NB_ADDR-1:0]  o_dump_addr,
  input  logic                i_dump_ready,
  output logic                o_dump_busy,
  output logic                o_dump_done
);

  typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;

  localparam logic [NB_ADDR-1:0] LAST_ADDR = {{(NB_ADDR-2){1'b1}}, 2'b00};
  localparam logic [NB_ADDR-1:0] WORD_STEP = NB_ADDR'(4);

  state_t              state, state_next;
  logic [NB_ADDR-1:0]  counter, counter_next;
  logic [NB_WIDTH-1:0] dump_data;
  logic [NB_ADDR-1:0]  dump_addr;
  logic                dump_valid;
  logic                transfer;

  assign transfer = (state == SEND) && i_dump_ready;

  always_comb begin
    state_next   = state;
    counter_next = counter;
    case (state)
      IDLE: if (i_dump_start) state_next = READ;
      READ: state_next = SEND;
      SEND: begin
        if (transfer) begin
          if (counter == LAST_ADDR) begin
            counter_next = '0;
            state_next   = DONE;
          end else begin
            counter_next = counter + WORD_STEP;
            state_next   = READ;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // Abort overrides everything, including a transfer in the same cycle.
    if ((state != IDLE) && i_dump_abort) begin
      state_next   = IDLE;
      counter_next = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= IDLE;
      counter    <= '0;
      dump_valid <= 1'b0;
      dump_data  <= '0;
      dump_addr  <= '0;
    end else begin
      state      <= state_next;
      counter    <= counter_next;
      dump_valid <= (state_next == SEND);
      if (state == READ) begin
        dump_data <= i_mem_rdata;
        dump_addr <= counter;
      end
    end
  end

  always_comb begin
    o_mem_we     = 1'b0;
    o_mem_addr   = NB_WIDTH'(counter);
    o_mem_wdata  = '0;
    o_mem_bhw    = 3'b011;
    o_pipe_rdata = '0;
    o_pipe_stall = i_pipe_read | i_pipe_write;
    if (state == IDLE) begin
      o_mem_we     = i_pipe_write;
      o_mem_addr   = i_pipe_addr;
      o_mem_wdata  = i_pipe_wdata;
      o_mem_bhw    = i_pipe_bhw;
      o_pipe_rdata = i_mem_rdata;
      o_pipe_stall = 1'b0;
    end
  end

  assign o_dump_valid = dump_valid;
  assign o_dump_data  = dump_data;
  assign o_dump_addr  = dump_addr;
  assign o_dump_busy  = (state != IDLE);
  assign o_dump_done  = (state == DONE) && !i_dump_abort;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter NB_WIDTH, default 32, data/address line width.
REQ-002 SHALL have parameter NB_ADDR, default 9, byte-address width of data RAM.
REQ-003 SHALL have ports i_clk in 1, system clock; i_reset in 1, reset (one clock; reset synchronous, active-high).
REQ-004 SHALL have i_pipe_read in 1, i_pipe_write in 1, i_pipe_addr in NB_WIDTH, i_pipe_wdata in NB_WIDTH, i_pipe_bhw in 3: pipeline MEM-stage request.
REQ-005 SHALL have o_mem_we out 1, o_mem_addr out NB_WIDTH, o_mem_wdata out NB_WIDTH, o_mem_bhw out 3: data-RAM port drive; i_mem_rdata in NB_WIDTH: async RAM read data.
REQ-006 SHALL have o_pipe_rdata out NB_WIDTH (read data to pipeline) and o_pipe_stall out 1 (pipeline must hold MEM stage).
REQ-007 SHALL have i_dump_start in 1 (debug-unit dump request pulse) and i_dump_abort in 1 (cancel dump).
REQ-008 SHALL have o_dump_valid out 1, o_dump_data out NB_WIDTH, o_dump_addr out NB_ADDR, i_dump_ready in 1: word stream to debug unit.
REQ-009 SHALL have o_dump_busy out 1 (state != IDLE) and o_dump_done out 1 (single-cycle completion pulse).

Function
REQ-010 SHALL implement FSM states IDLE, READ, SEND, DONE.
REQ-011 IDLE: port owned by pipeline; o_mem_* = i_pipe_addr/i_pipe_wdata/i_pipe_bhw, o_mem_we = i_pipe_write; o_pipe_rdata = i_mem_rdata; o_pipe_stall = 0.
REQ-012 IDLE + i_dump_start -> READ next cycle; a pipeline access in that same cycle completes normally (pipeline wins the tie).
REQ-013 i_dump_start SHALL be ignored in any state other than IDLE.
REQ-014 Non-IDLE: o_mem_we = 0, o_mem_bhw = 3'b011, o_mem_wdata = 0, o_mem_addr = zero-extended word counter; o_pipe_stall = i_pipe_read | i_pipe_write; o_pipe_rdata = 0.
REQ-015 READ (1 cycle): o_dump_data <= i_mem_rdata, o_dump_addr <= counter; -> SEND.
REQ-016 SEND: o_dump_valid = 1; data/addr held stable until i_dump_ready = 1 sampled with valid (transfer).
REQ-017 On transfer: counter < 2^NB_ADDR-4 -> counter += 4, -> READ; counter = 2^NB_ADDR-4 -> counter <= 0, -> DONE.
REQ-018 Each dump SHALL emit exactly 2^(NB_ADDR-2) words (128 at default), addresses 0,4,...,508, in order, no skips or repeats.
REQ-019 DONE: o_dump_done = 1 for exactly one cycle; -> IDLE.
REQ-020 i_dump_abort in READ/SEND/DONE -> IDLE next cycle, counter <= 0, o_dump_valid <= 0, no o_dump_done pulse; abort in IDLE has no effect; abort wins over a simultaneous SEND transfer.
REQ-021 o_dump_valid SHALL be registered, asserted only in SEND; never asserted while o_mem_we = 1.

Reset
REQ-022 i_reset=1 at a clock edge: state IDLE, counter 0, o_dump_valid 0, o_dump_done 0, o_dump_data 0, o_dump_addr 0; o_dump_busy 0, o_pipe_stall 0.
REQ-023 Reset mid-dump SHALL abandon the dump without a done pulse; next i_dump_start restarts from address 0.

Verification
REQ-024 RAM preloaded word[n]=n*0x01010101; i_dump_start, i_dump_ready=1 -> 128 transfers, addr 0..508 step 4, data matches, o_dump_done one pulse, READ/SEND 2 cycles/word.
REQ-025 i_dump_ready toggled randomly during dump -> o_dump_data/o_dump_addr stable while valid and not ready; no word lost/duplicated.
REQ-026 i_pipe_write=1 addr 0x10 data 0xDEADBEEF same cycle as i_dump_start -> write lands (o_mem_we=1 that cycle), dump later returns 0xDEADBEEF at addr 0x10.
REQ-027 Pipeline read during dump -> o_pipe_stall=1, o_mem_we=0 every non-IDLE cycle; stall clears the cycle after DONE.
REQ-028 i_dump_abort at word 5 SEND -> IDLE next cycle, no done pulse; new start emits addr 0 first.
REQ-029 i_reset during SEND at word 60 -> all outputs at REQ-022 values next cycle; i_dump_start during busy ignored (word count stays 128).
